servo_cmd_ctrl: RTL and testbench

//  Command sequencer between the UART receiver/transmitter and the servo PWM generator.

---
 rtl/servo_cmd_pkg.sv | 35 +++
 rtl/servo_cmd_tx_seq.sv | 93 +++++++++
 rtl/servo_cmd_ctrl.sv | 167 ++++++++++++++++
 tb/tb_servo_cmd_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_cmd_pkg.sv
// servo_cmd_pkg: shared definitions for the servo command sequencer.
//   - parser and TX-sequencer state encodings
//   - frame byte constants (header, commands, ACK/NAK)
//   - NAK reason codes
package servo_cmd_pkg;

    // Parser states; ST_TX covers TX0/TX0_W/TX1/TX1_W, which the TX sequencer tracks itself.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_DATA,
        ST_GET_CHK,
        ST_EXEC,
        ST_TX
    } parse_state_t;

    typedef enum logic [2:0] {
        TS_IDLE,
        TS_TX0,
        TS_TX0_W,
        TS_TX1,
        TS_TX1_W
    } tx_state_t;

    localparam logic [7:0] HDR     = 8'hAA;
    localparam logic [7:0] CMD_SET = 8'h01;
    localparam logic [7:0] CMD_GET = 8'h02;
    localparam logic [7:0] ACK     = 8'h06;
    localparam logic [7:0] NAK     = 8'h15;

    localparam logic [7:0] ERR_CHK   = 8'h01;
    localparam logic [7:0] ERR_RANGE = 8'h02;
    localparam logic [7:0] ERR_CMD   = 8'h03;

endpackage

// File: rtl/servo_cmd_tx_seq.sv
// servo_cmd_tx_seq: sends a 2-byte response over a busy-handshake transmitter.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           one-cycle request; byte0_i/byte1_i are latched with it
//   byte0_i, byte1_i  response bytes, sent in that order
//   tx_busy_i         transmitter busy
//   tx_en_o           one-cycle send request (only issued while tx_busy_i is low)
//   tx_data_o         byte being sent; stable from tx_en_o until the wait state ends
//   done_o            one-cycle pulse in the cycle the second byte's wait state ends
module servo_cmd_tx_seq
    import servo_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] byte0_i,
    input  logic [7:0] byte1_i,
    input  logic       tx_busy_i,
    output logic       tx_en_o,
    output logic [7:0] tx_data_o,
    output logic       done_o
);

    tx_state_t  state_q, state_d;
    logic [7:0] data_q;
    logic [7:0] byte1_q;
    logic       seen_busy_q;
    logic       guard_q;
    logic       wait_done;

    // A wait state ends when busy has risen and fallen, or when busy is still
    // low two cycles after tx_en (the transmitter's busy pulse was missed).
    always_comb begin
        wait_done = !tx_busy_i && (seen_busy_q || guard_q);
        state_d   = state_q;
        tx_en_o   = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            TS_IDLE:  if (start_i) state_d = TS_TX0;
            TS_TX0: begin
                if (!tx_busy_i) begin
                    tx_en_o = 1'b1;
                    state_d = TS_TX0_W;
                end
            end
            TS_TX0_W: if (wait_done) state_d = TS_TX1;
            TS_TX1: begin
                if (!tx_busy_i) begin
                    tx_en_o = 1'b1;
                    state_d = TS_TX1_W;
                end
            end
            TS_TX1_W: begin
                if (wait_done) begin
                    state_d = TS_IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = TS_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= TS_IDLE;
            data_q      <= 8'h00;
            seen_busy_q <= 1'b0;
            guard_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == TS_IDLE && start_i) begin
                data_q <= byte0_i;
            end else if (state_q == TS_TX0_W && wait_done) begin
                data_q <= byte1_q;
            end
            // Wait-state trackers restart on every tx_en.
            if (tx_en_o) begin
                seen_busy_q <= 1'b0;
                guard_q     <= 1'b0;
            end else begin
                if (tx_busy_i) seen_busy_q <= 1'b1;
                guard_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == TS_IDLE && start_i) byte1_q <= byte1_i;
    end

    assign tx_data_o = data_q;

endmodule

// File: rtl/servo_cmd_ctrl.sv
// servo_cmd_ctrl: parses 4-byte frames (AA, CMD, DATA, CMD^DATA) from the UART
// receiver, sets or reads back the servo angle, and answers with 2 bytes.
// Ports:
//   clk          system clock
//   reset_uart   synchronous active-high reset
//   rx_valid     one-cycle strobe, rx_data holds a new byte
//   rx_data      received byte
//   tx_busy      transmitter busy
//   tx_en        one-cycle send request
//   tx_data      byte to send
//   pwm_width    servo high time in clk cycles
//   pwm_update   one-cycle strobe when pwm_width changes
//   status_leds  [0] ok toggle, [1] sticky NAK, [2] sticky rx overrun, [3] tx in progress
// Optional feature: define SERVO_CMD_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYC cycles without a byte; otherwise a partial frame waits indefinitely.
module servo_cmd_ctrl
    import servo_cmd_pkg::*;
#(
    parameter int CLK_HZ      = 27_000_000,
    parameter int MIN_CYC     = CLK_HZ / 1000,
    parameter int STEP_CYC    = CLK_HZ / 180_000,
    parameter int MAX_ANGLE   = 180,
    parameter int PW_BITS     = 17,
    parameter int TIMEOUT_CYC = CLK_HZ / 100
) (
    input  logic               clk,
    input  logic               reset_uart,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               tx_busy,
    output logic               tx_en,
    output logic [7:0]         tx_data,
    output logic [PW_BITS-1:0] pwm_width,
    output logic               pwm_update,
    output logic [3:0]         status_leds
);

    if (MAX_ANGLE > 255 || TIMEOUT_CYC < 2 ||
        MIN_CYC + MAX_ANGLE * STEP_CYC >= (1 << PW_BITS)) begin : g_param_check
        $error("servo_cmd_ctrl: parameter set out of range");
    end

    function automatic logic [PW_BITS-1:0] angle_to_width(input logic [7:0] angle);
        return PW_BITS'(MIN_CYC) + PW_BITS'(angle) * PW_BITS'(STEP_CYC);
    endfunction

    parse_state_t       state_q, state_d;
    logic [7:0]         cmd_q, data_q, chk_q;
    logic [7:0]         angle_q;
    logic [PW_BITS-1:0] pwm_width_q;
    logic               pwm_update_q;
    logic               ok_q, nak_q, ovr_q;
    logic [7:0]         resp0, resp1;
    logic               set_ok, get_ok;
    logic               tx_start, tx_done, overrun, in_get, to_hit;

    assign in_get   = (state_q == ST_GET_CMD) || (state_q == ST_GET_DATA) || (state_q == ST_GET_CHK);
    assign tx_start = (state_q == ST_EXEC);
    // A byte landing in the cycle the response completes is handled as if in IDLE.
    assign overrun  = rx_valid && ((state_q == ST_EXEC) || (state_q == ST_TX && !tx_done));

    // Validation, checked in priority order: checksum, range, command.
    always_comb begin
        resp0  = ACK;
        resp1  = angle_q;
        set_ok = 1'b0;
        get_ok = 1'b0;
        if ((cmd_q ^ data_q) != chk_q) begin
            resp0 = NAK;
            resp1 = ERR_CHK;
        end else if (cmd_q == CMD_SET && data_q > 8'(MAX_ANGLE)) begin
            resp0 = NAK;
            resp1 = ERR_RANGE;
        end else if (cmd_q == CMD_SET) begin
            set_ok = 1'b1;
            resp1  = data_q;
        end else if (cmd_q == CMD_GET) begin
            get_ok = 1'b1;
        end else begin
            resp0 = NAK;
            resp1 = ERR_CMD;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (rx_valid && rx_data == HDR) state_d = ST_GET_CMD;
            ST_GET_CMD:  if (rx_valid) state_d = ST_GET_DATA;
            ST_GET_DATA: if (rx_valid) state_d = ST_GET_CHK;
            ST_GET_CHK:  if (rx_valid) state_d = ST_EXEC;
            ST_EXEC:     state_d = ST_TX;
            ST_TX: begin
                if (tx_done) state_d = (rx_valid && rx_data == HDR) ? ST_GET_CMD : ST_IDLE;
            end
            default:     state_d = ST_IDLE;
        endcase
        if (to_hit) state_d = ST_IDLE;
    end

`ifdef SERVO_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;

    assign to_hit = in_get && !rx_valid && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset_uart || !in_get || rx_valid || to_hit) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset_uart) begin
            state_q      <= ST_IDLE;
            angle_q      <= 8'd90;
            pwm_width_q  <= angle_to_width(8'd90);
            pwm_update_q <= 1'b0;
            ok_q         <= 1'b0;
            nak_q        <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwm_update_q <= 1'b0;
            if (state_q == ST_EXEC) begin
                if (set_ok) begin
                    angle_q      <= data_q;
                    pwm_width_q  <= angle_to_width(data_q);
                    pwm_update_q <= 1'b1;
                end
                if (set_ok || get_ok) ok_q  <= ~ok_q;
                else                  nak_q <= 1'b1;
            end
            if (overrun) ovr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_valid) begin
            if (state_q == ST_GET_CMD)  cmd_q  <= rx_data;
            if (state_q == ST_GET_DATA) data_q <= rx_data;
            if (state_q == ST_GET_CHK)  chk_q  <= rx_data;
        end
    end

    servo_cmd_tx_seq u_tx_seq (
        .clk_i     (clk),
        .rst_i     (reset_uart),
        .start_i   (tx_start),
        .byte0_i   (resp0),
        .byte1_i   (resp1),
        .tx_busy_i (tx_busy),
        .tx_en_o   (tx_en),
        .tx_data_o (tx_data),
        .done_o    (tx_done)
    );

    assign pwm_width   = pwm_width_q;
    assign pwm_update  = pwm_update_q;
    assign status_leds = {(state_q == ST_EXEC) || (state_q == ST_TX), ovr_q, nak_q, ok_q};

endmodule

// File: tb/tb_servo_cmd_ctrl.sv
module tb_servo_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset_uart;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_busy = 1'b0;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic [16:0] pwm_width;
    logic        pwm_update;
    logic [3:0]  status_leds;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  txq[$];
    int          upd_cnt = 0;
    int          txen_long = 0;
    bit          prev_en = 1'b0;
    bit          start_pending = 1'b0;
    int          busy_cnt = 0;
    bit          busy_hold = 1'b0;
    bit          no_busy = 1'b0;

    int          base;
    int          u0;
    bit          exp_led0;

    always #5 clk = ~clk;

    servo_cmd_ctrl dut (
        .clk         (clk),
        .reset_uart  (reset_uart),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_busy     (tx_busy),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .pwm_width   (pwm_width),
        .pwm_update  (pwm_update),
        .status_leds (status_leds)
    );

    // Transmitter model: captures bytes on tx_en, raises busy just after the
    // following clock edge for 6 cycles (unless no_busy), or holds it on busy_hold.
    initial begin
        forever begin
            @(negedge clk);
            if (pwm_update) upd_cnt++;
            if (tx_en && prev_en) txen_long++;
            if (tx_en && !prev_en) begin
                txq.push_back(tx_data);
                start_pending = !no_busy;
            end
            prev_en = tx_en;
            @(posedge clk);
            #1;
            if (busy_cnt > 0) busy_cnt--;
            if (start_pending) begin
                busy_cnt      = 6;
                start_pending = 1'b0;
            end
            tx_busy = busy_hold || (busy_cnt > 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic wait_tx(input int n, input string name);
        int k;
        k = 0;
        while (txq.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        while (status_leds[3] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: got %0d bytes, expected %0d", name, txq.size(), n);
        end
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] r0, r1;
        int         pw;
        int         upd;
        bit         ok;
        bit         led1;
    } vec_t;

    vec_t tv[11];

    initial begin
        tv[0]  = '{8'hAA, 8'h02, 8'h00, 8'h02, 8'h06, 8'h5A, 40500, 0, 1'b1, 1'b0};
        tv[1]  = '{8'hAA, 8'h01, 8'hB5, 8'hB4, 8'h15, 8'h02, 40500, 0, 1'b0, 1'b1};
        tv[2]  = '{8'hAA, 8'h01, 8'h2D, 8'h2C, 8'h06, 8'h2D, 33750, 1, 1'b1, 1'b1};
        tv[3]  = '{8'hAA, 8'h01, 8'h5A, 8'h00, 8'h15, 8'h01, 33750, 0, 1'b0, 1'b1};
        tv[4]  = '{8'hAA, 8'h02, 8'h00, 8'h02, 8'h06, 8'h2D, 33750, 0, 1'b1, 1'b1};
        tv[5]  = '{8'hAA, 8'h01, 8'hB4, 8'hB5, 8'h06, 8'hB4, 54000, 1, 1'b1, 1'b1};
        tv[6]  = '{8'hAA, 8'h03, 8'h00, 8'h03, 8'h15, 8'h03, 54000, 0, 1'b0, 1'b1};
        tv[7]  = '{8'hAA, 8'h01, 8'h00, 8'h01, 8'h06, 8'h00, 27000, 1, 1'b1, 1'b1};
        tv[8]  = '{8'hAA, 8'h02, 8'h77, 8'h75, 8'h06, 8'h00, 27000, 0, 1'b1, 1'b1};
        tv[9]  = '{8'hAA, 8'h01, 8'hB5, 8'h00, 8'h15, 8'h01, 27000, 0, 1'b0, 1'b1};
        tv[10] = '{8'hAA, 8'h01, 8'h5A, 8'h5B, 8'h06, 8'h5A, 40500, 1, 1'b1, 1'b1};

        reset_uart = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        repeat (3) @(negedge clk);
        reset_uart = 1'b0;

        check("rst_tx_en", tx_en, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_pwm_width", pwm_width, 40500);
        check("rst_pwm_update", pwm_update, 0);
        check("rst_leds", status_leds, 0);

        exp_led0 = 1'b0;
        for (int i = 0; i < 11; i++) begin
            base = txq.size();
            u0   = upd_cnt;
            send_frame(tv[i].b0, tv[i].b1, tv[i].b2, tv[i].b3);
            wait_tx(base + 2, $sformatf("v%0d", i));
            exp_led0 ^= tv[i].ok;
            check($sformatf("v%0d_count", i), txq.size(), base + 2);
            check($sformatf("v%0d_tx0", i), txq[base], tv[i].r0);
            check($sformatf("v%0d_tx1", i), txq[base+1], tv[i].r1);
            check($sformatf("v%0d_pwm", i), pwm_width, tv[i].pw);
            check($sformatf("v%0d_upd", i), upd_cnt - u0, tv[i].upd);
            check($sformatf("v%0d_led0", i), status_leds[0], exp_led0);
            check($sformatf("v%0d_led1", i), status_leds[1], tv[i].led1);
        end

        // Latency from CHK strobe to first tx_en, and pwm_update timing.
        base = txq.size();
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h14);
        rx_data  = 8'h15;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("lat_exec_tx_en", tx_en, 0);
        @(negedge clk);
        check("lat_tx_en", tx_en, 1);
        check("lat_upd", pwm_update, 1);
        check("lat_pwm", pwm_width, 30000);
        wait_tx(base + 2, "lat");
        check("lat_tx0", txq[base], 8'h06);
        check("lat_tx1", txq[base+1], 8'h14);

        // Transmitter held busy, then a byte arriving during the response.
        busy_hold = 1'b1;
        repeat (2) @(negedge clk);
        base = txq.size();
        u0   = upd_cnt;
        send_frame(8'hAA, 8'h01, 8'h1E, 8'h1F);
        repeat (1000) @(negedge clk);
        check("busy_no_tx_en", txq.size(), base);
        check("busy_led3", status_leds[3], 1);
        check("busy_led2_clear", status_leds[2], 0);
        busy_hold = 1'b0;
        for (int k = 0; k < 200 && txq.size() == base; k++) @(negedge clk);
        check("busy_first_byte", txq.size(), base + 1);
        @(negedge clk);
        send_byte(8'h33);
        check("busy_overrun", status_leds[2], 1);
        wait_tx(base + 2, "busy");
        check("busy_tx0", txq[base], 8'h06);
        check("busy_tx1", txq[base+1], 8'h1E);
        check("busy_pwm", pwm_width, 31500);
        check("busy_upd", upd_cnt - u0, 1);

        // Missed busy pulse: the guard must still advance through both bytes.
        no_busy = 1'b1;
        base = txq.size();
        send_frame(8'hAA, 8'h02, 8'h00, 8'h02);
        wait_tx(base + 2, "guard");
        no_busy = 1'b0;
        check("guard_tx0", txq[base], 8'h06);
        check("guard_tx1", txq[base+1], 8'h1E);

        // Stray bytes before a header, then reset in the middle of a frame.
        base = txq.size();
        send_byte(8'h55);
        send_byte(8'h00);
        send_frame(8'hAA, 8'h01, 8'h00, 8'h01);
        wait_tx(base + 2, "stray");
        check("stray_count", txq.size(), base + 2);
        check("stray_tx1", txq[base+1], 8'h00);
        check("stray_pwm", pwm_width, 27000);
        send_byte(8'hAA);
        send_byte(8'h01);
        reset_uart = 1'b1;
        @(negedge clk);
        reset_uart = 1'b0;
        check("mid_rst_pwm", pwm_width, 40500);
        check("mid_rst_leds", status_leds, 0);
        check("mid_rst_tx_en", tx_en, 0);
        check("mid_rst_tx_data", tx_data, 0);
        check("mid_rst_upd", pwm_update, 0);
        base = txq.size();
        send_frame(8'hAA, 8'h02, 8'h00, 8'h02);
        wait_tx(base + 2, "post_rst");
        check("post_rst_tx0", txq[base], 8'h06);
        check("post_rst_tx1", txq[base+1], 8'h5A);

        // Partial frame followed by a full frame: the second header is data.
        send_byte(8'hAA);
        send_byte(8'h01);
        repeat (500) @(negedge clk);
        base = txq.size();
        send_frame(8'hAA, 8'h01, 8'h0A, 8'h0B);
        wait_tx(base + 2, "partial");
        repeat (50) @(negedge clk);
        check("partial_count", txq.size(), base + 2);
        check("partial_tx0", txq[base], 8'h15);
        check("partial_tx1", txq[base+1], 8'h01);
        check("partial_led1", status_leds[1], 1);
        check("partial_overrun", status_leds[2], 1);
        check("partial_pwm", pwm_width, 40500);

        check("tx_en_width", txen_long, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
